bullet_engine: RTL and testbench



---
 rtl/bullet_pkg.sv | 24 ++
 rtl/bullet_sprite_rom.sv | 47 ++++
 rtl/bullet_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_bullet_engine.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet engine: direction encoding, slot record,
// and the fixed sprite geometry. Optional collision logic: BULLET_COLLIDE_EN.
package bullet_pkg;

  localparam int          POS_W           = 16;
  localparam int          SPRITE_SIZE     = 10;
  localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Positions are held wider than any supported COORD_W so the move/bound maths never wraps.
  typedef struct packed {
    logic             active;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    dir_e             dir;
  } slot_t;

endpackage

// File: rtl/bullet_sprite_rom.sv
// 10x10 bullet sprite, 12-bit colour, address {lx, ly}, registered one-cycle read.
module bullet_sprite_rom
  import bullet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  addr_i,
  output logic [11:0] data_o
);

  logic [11:0] data_q;
  logic [11:0] data_d;

  function automatic logic [11:0] sprite_pixel(input logic [3:0] lx, input logic [3:0] ly);
    logic [11:0] px;
    px = 12'h222;
    if ((ly == 4'd0 || ly == 4'd9) && (lx <= 4'd1 || lx >= 4'd8)) begin
      px = TRANSPARENT_KEY;
    end else if ((ly == 4'd1 || ly == 4'd8) && (lx == 4'd0 || lx == 4'd9)) begin
      px = TRANSPARENT_KEY;
    end else if (lx == 4'd4 && ly == 4'd4) begin
      px = 12'hFFF;
    end else if ((ly == 4'd2 || ly == 4'd7) && lx >= 4'd4 && lx <= 4'd5) begin
      px = 12'h000;
    end else if ((ly == 4'd3 || ly == 4'd6) && lx >= 4'd3 && lx <= 4'd6) begin
      px = 12'h000;
    end else if ((ly == 4'd4 || ly == 4'd5) && lx >= 4'd2 && lx <= 4'd7) begin
      px = 12'h000;
    end
    return px;
  endfunction

  always_comb begin
    data_d = sprite_pixel(addr_i[7:4], addr_i[3:0]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= 12'h000;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bullet_engine.sv
// Multi-slot bullet engine: fire handshake, per-frame movement and a 2-cycle sprite render path.
// Define BULLET_COLLIDE_EN to add target-box collision freeing and hit reporting.
module bullet_engine #(
  parameter int          NUM_BULLETS     = 4,
  parameter int          COORD_W         = 10,
  parameter int          SCREEN_W        = 640,
  parameter int          SCREEN_H        = 480,
  parameter int          SPRITE_SIZE     = 10,
  parameter int          SPEED           = 4,
  parameter logic [11:0] TRANSPARENT_KEY = bullet_pkg::TRANSPARENT_KEY
) (
  input  logic                   Master_Clock_In,
  input  logic                   Master_Reset_n_In,
  input  logic                   Frame_Tick_In,
  input  logic                   Fire_Valid_In,
  output logic                   Fire_Ready_Out,
  input  logic [COORD_W-1:0]     Fire_X_In,
  input  logic [COORD_W-1:0]     Fire_Y_In,
  input  logic [1:0]             Fire_Dir_In,
  input  logic [COORD_W-1:0]     xInput,
  input  logic [COORD_W-1:0]     yInput,
  output logic [11:0]            ColourData,
  output logic                   Pixel_Hit_Out,
`ifdef BULLET_COLLIDE_EN
  input  logic [COORD_W-1:0]     Target_X_In,
  input  logic [COORD_W-1:0]     Target_Y_In,
  output logic                   Hit_Pulse_Out,
  output logic [7:0]             Hit_Count_Out,
`endif
  output logic [NUM_BULLETS-1:0] Active_Mask_Out
);

  import bullet_pkg::*;

  localparam logic [POS_W-1:0] X_MAX = POS_W'(SCREEN_W - SPRITE_SIZE);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(SCREEN_H - SPRITE_SIZE);
  localparam logic [POS_W-1:0] SPD   = POS_W'(SPEED);
  localparam logic [POS_W-1:0] SS    = POS_W'(SPRITE_SIZE);

  slot_t slot_q [NUM_BULLETS];
  slot_t slot_d [NUM_BULLETS];

  logic [NUM_BULLETS-1:0] active_vec;
  logic [NUM_BULLETS-1:0] spawn_sel;
  logic                   fire_acc;
  logic                   taken;
  logic [POS_W-1:0]       fire_x;
  logic [POS_W-1:0]       fire_y;

  logic             found1_q, found1_d;
  logic [3:0]       lx_q, lx_d;
  logic [3:0]       ly_q, ly_d;
  logic             found2_q;
  logic [11:0]      rom_data;
  logic [POS_W-1:0] scan_x, scan_y, dx, dy;

`ifdef BULLET_COLLIDE_EN
  logic             tick_q;
  logic             hit_pulse_q, hit_pulse_d;
  logic [7:0]       hit_count_q, hit_count_d;
  logic [3:0]       hit_n;
  logic [8:0]       hit_sum;
  logic [POS_W-1:0] tgt_x, tgt_y, ox, oy;
`endif

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      active_vec[i] = slot_q[i].active;
    end
  end

  assign Fire_Ready_Out  = ~(&active_vec);
  assign Active_Mask_Out = active_vec;
  assign fire_acc        = Fire_Valid_In & Fire_Ready_Out;

  always_comb begin
    fire_x = POS_W'(Fire_X_In);
    fire_y = POS_W'(Fire_Y_In);
    if (fire_x > X_MAX) fire_x = X_MAX;
    if (fire_y > Y_MAX) fire_y = Y_MAX;
  end

  // Lowest-index inactive slot receives the spawn.
  always_comb begin
    spawn_sel = '0;
    taken     = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!slot_q[i].active && !taken) begin
        spawn_sel[i] = 1'b1;
        taken        = 1'b1;
      end
    end
  end

`ifdef BULLET_COLLIDE_EN
  assign tgt_x = POS_W'(Target_X_In);
  assign tgt_y = POS_W'(Target_Y_In);
`endif

  always_comb begin
    slot_d = slot_q;
`ifdef BULLET_COLLIDE_EN
    hit_n = 4'd0;
    ox    = '0;
    oy    = '0;
`endif
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (Frame_Tick_In && slot_q[i].active) begin
        unique case (slot_q[i].dir)
          DIR_UP: begin
            if (slot_q[i].y < SPD) slot_d[i].active = 1'b0;
            else                   slot_d[i].y = slot_q[i].y - SPD;
          end
          DIR_DOWN: begin
            if (slot_q[i].y + SPD > Y_MAX) slot_d[i].active = 1'b0;
            else                           slot_d[i].y = slot_q[i].y + SPD;
          end
          DIR_LEFT: begin
            if (slot_q[i].x < SPD) slot_d[i].active = 1'b0;
            else                   slot_d[i].x = slot_q[i].x - SPD;
          end
          DIR_RIGHT: begin
            if (slot_q[i].x + SPD > X_MAX) slot_d[i].active = 1'b0;
            else                           slot_d[i].x = slot_q[i].x + SPD;
          end
          default: slot_d[i].active = 1'b0;
        endcase
      end
`ifdef BULLET_COLLIDE_EN
      // Collision uses the positions settled by the previous cycle's tick.
      ox = (slot_q[i].x >= tgt_x) ? slot_q[i].x - tgt_x : tgt_x - slot_q[i].x;
      oy = (slot_q[i].y >= tgt_y) ? slot_q[i].y - tgt_y : tgt_y - slot_q[i].y;
      if (tick_q && slot_q[i].active && ox < SS && oy < SS) begin
        slot_d[i].active = 1'b0;
        hit_n            = hit_n + 4'd1;
      end
`endif
      if (fire_acc && spawn_sel[i]) begin
        slot_d[i].active = 1'b1;
        slot_d[i].x      = fire_x;
        slot_d[i].y      = fire_y;
        slot_d[i].dir    = dir_e'(Fire_Dir_In);
      end
    end
  end

`ifdef BULLET_COLLIDE_EN
  always_comb begin
    hit_pulse_d = hit_n != 4'd0;
    hit_sum     = {1'b0, hit_count_q} + {5'd0, hit_n};
    hit_count_d = (hit_sum > 9'd255) ? 8'd255 : hit_sum[7:0];
  end
`endif

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_n_In) begin
    if (!Master_Reset_n_In) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        slot_q[i] <= '{active: 1'b0, x: '0, y: '0, dir: DIR_UP};
      end
`ifdef BULLET_COLLIDE_EN
      tick_q      <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= 8'd0;
`endif
    end else begin
      slot_q <= slot_d;
`ifdef BULLET_COLLIDE_EN
      tick_q      <= Frame_Tick_In;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
`endif
    end
  end

`ifdef BULLET_COLLIDE_EN
  assign Hit_Pulse_Out = hit_pulse_q;
  assign Hit_Count_Out = hit_count_q;
`endif

  // Stage 1: walk slots high to low so the lowest-index in-box slot is the one kept.
  always_comb begin
    scan_x   = POS_W'(xInput);
    scan_y   = POS_W'(yInput);
    found1_d = 1'b0;
    lx_d     = 4'd0;
    ly_d     = 4'd0;
    dx       = '0;
    dy       = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      dx = scan_x - slot_q[i].x;
      dy = scan_y - slot_q[i].y;
      if (slot_q[i].active && scan_x >= slot_q[i].x && dx < SS &&
          scan_y >= slot_q[i].y && dy < SS) begin
        found1_d = 1'b1;
        lx_d     = dx[3:0];
        ly_d     = dy[3:0];
      end
    end
  end

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_n_In) begin
    if (!Master_Reset_n_In) begin
      found1_q <= 1'b0;
      lx_q     <= 4'd0;
      ly_q     <= 4'd0;
      found2_q <= 1'b0;
    end else begin
      found1_q <= found1_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      found2_q <= found1_q;
    end
  end

  bullet_sprite_rom u_rom (
    .clk_i   (Master_Clock_In),
    .rst_n_i (Master_Reset_n_In),
    .addr_i  ({lx_q, ly_q}),
    .data_o  (rom_data)
  );

  assign Pixel_Hit_Out = found2_q && (rom_data != TRANSPARENT_KEY);
  assign ColourData    = Pixel_Hit_Out ? rom_data : 12'h000;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: spawn, movement bounds, render priority, reset, optional collision.
module tb_bullet_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       fv;
  logic       ready;
  logic [9:0] fx, fy;
  logic [1:0] fdir;
  logic [9:0] xin, yin;
  logic [11:0] colour;
  logic       hit;
  logic [3:0] mask;
`ifdef BULLET_COLLIDE_EN
  logic [9:0] tx, ty;
  logic       hpulse;
  logic [7:0] hcount;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bullet_engine dut (
    .Master_Clock_In   (clk),
    .Master_Reset_n_In (rst_n),
    .Frame_Tick_In     (tick),
    .Fire_Valid_In     (fv),
    .Fire_Ready_Out    (ready),
    .Fire_X_In         (fx),
    .Fire_Y_In         (fy),
    .Fire_Dir_In       (fdir),
    .xInput            (xin),
    .yInput            (yin),
    .ColourData        (colour),
    .Pixel_Hit_Out     (hit),
`ifdef BULLET_COLLIDE_EN
    .Target_X_In       (tx),
    .Target_Y_In       (ty),
    .Hit_Pulse_Out     (hpulse),
    .Hit_Count_Out     (hcount),
`endif
    .Active_Mask_Out   (mask)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
    fv = 1'b1; fx = x; fy = y; fdir = d;
    cyc();
    fv = 1'b0;
  endtask

  task automatic frame_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [11:0] exp_c, input logic exp_h);
    xin = x; yin = y;
    cyc();
    cyc();
    chk({tag, "_colour"}, 16'(colour), 16'(exp_c));
    chk({tag, "_hit"}, 16'(hit), 16'(exp_h));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; fv = 1'b0; fx = '0; fy = '0; fdir = 2'd0;
    xin = '0; yin = '0;
`ifdef BULLET_COLLIDE_EN
    tx = 10'd0; ty = 10'd460;
`endif
    #3;
    chk("rst_mask", 16'(mask), 16'h0);
    chk("rst_colour", 16'(colour), 16'h0);
    chk("rst_hit", 16'(hit), 16'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", 16'(ready), 16'h1);

    // Single spawn and render of highlight, transparent corner and opaque black core
    fire(10'd100, 10'd200, 2'd0);
    chk("spawn_mask", 16'(mask), 16'h1);
    probe("hl", 10'd104, 10'd204, 12'hFFF, 1'b1);
    probe("corner", 10'd100, 10'd200, 12'h000, 1'b0);
    probe("core", 10'd105, 10'd204, 12'h000, 1'b1);

    // Fill all slots, including a clamped spawn
    fire(10'd700, 10'd475, 2'd2);
    fire(10'd300, 10'd100, 2'd1);
    fire(10'd400, 10'd100, 2'd1);
    chk("full_ready", 16'(ready), 16'h0);
    chk("full_mask", 16'(mask), 16'hF);
    fire(10'd50, 10'd50, 2'd0);
    chk("fifth_ignored", 16'(mask), 16'hF);
    probe("clamp", 10'd634, 10'd474, 12'hFFF, 1'b1);

    // Edge deactivation
    do_reset();
    cyc();
    fire(10'd200, 10'd3, 2'd0);
    frame_tick();
    chk("top_edge_free", 16'(mask), 16'h0);
    fire(10'd626, 10'd50, 2'd3);
    frame_tick();
    chk("right_move_mask", 16'(mask), 16'h1);
    probe("right_630", 10'd634, 10'd54, 12'hFFF, 1'b1);
    frame_tick();
    chk("right_edge_free", 16'(mask), 16'h0);

    // Spawn and tick in the same cycle
    do_reset();
    cyc();
    fire(10'd200, 10'd100, 2'd0);
    fv = 1'b1; fx = 10'd300; fy = 10'd300; fdir = 2'd1; tick = 1'b1;
    cyc();
    fv = 1'b0; tick = 1'b0;
    chk("same_cycle_mask", 16'(mask), 16'h3);
    probe("slot0_moved", 10'd204, 10'd100, 12'hFFF, 1'b1);
    probe("slot1_unmoved", 10'd304, 10'd304, 12'hFFF, 1'b1);

    // Overlap priority then mid-frame reset
    do_reset();
    cyc();
    fire(10'd48, 10'd48, 2'd0);
    fire(10'd400, 10'd400, 2'd0);
    fire(10'd46, 10'd46, 2'd0);
    chk("prio_mask", 16'(mask), 16'h7);
    probe("prio", 10'd50, 10'd50, 12'h222, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_colour", 16'(colour), 16'h0);
    chk("midrst_hit", 16'(hit), 16'h0);
    chk("midrst_mask", 16'(mask), 16'h0);
    rst_n = 1'b1;
    cyc();

`ifdef BULLET_COLLIDE_EN
    do_reset();
    cyc();
    tx = 10'd300; ty = 10'd300;
    fire(10'd300, 10'd306, 2'd0);
    frame_tick();
    chk("col_before_mask", 16'(mask), 16'h1);
    chk("col_before_pulse", 16'(hpulse), 16'h0);
    cyc();
    chk("col_pulse", 16'(hpulse), 16'h1);
    chk("col_count", 16'(hcount), 16'h1);
    chk("col_freed", 16'(mask), 16'h0);
    cyc();
    chk("col_pulse_end", 16'(hpulse), 16'h0);
    chk("col_count_hold", 16'(hcount), 16'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
